// File: rtl/fpga_step_loader_if.sv
// ALU-side bus of the step loader: operands and opcode out, result and sign flags back.
// The loader takes the master modport and the external ALU takes the slave modport.
interface fpga_step_loader_if;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [3:0]  alu_op;
    logic [15:0] alu_result;
    logic        alu_n;
    logic        alu_z;
    logic        alu_p;

    modport master (
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_n, alu_z, alu_p
    );

    modport slave (
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_n, alu_z, alu_p
    );
endinterface

// File: rtl/fpga_step_loader.sv
// Step loader: a debounced pushbutton walks through operand A, operand B and opcode entry,
// latches one external ALU result and shows it on the LEDs.
module fpga_step_loader #(
    parameter int DB_CYCLES = 250000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [9:0]                 sw,
    input  logic                       key_step,
    fpga_step_loader_if.master         alu,
    output logic [9:0]                 ledr,
    output logic [2:0]                 state
);

    typedef enum logic [2:0] {
        S_A    = 3'b000,
        S_B    = 3'b001,
        S_OP   = 3'b010,
        S_EXEC = 3'b011,
        S_SHOW = 3'b100
    } state_t;

    localparam logic [19:0] DB_LAST = 20'(DB_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic        cap_a;
    logic        cap_b;
    logic        cap_op;
    logic        cap_res;

    logic        sync1;
    logic        sync2;
    logic        db_level;
    logic [19:0] db_cnt;
    logic        press;

    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [3:0]  op_reg;
    logic [15:0] res_reg;
    logic        n_reg;
    logic        z_reg;
    logic        p_reg;

    // Pulse only on a debounced 1->0 transition, so a release never advances the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            db_level <= 1'b1;
            db_cnt   <= '0;
            press    <= 1'b0;
        end else begin
            sync1 <= key_step;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync2;
                    db_cnt   <= '0;
                    press    <= db_level & ~sync2;
                end else begin
                    db_cnt <= db_cnt + 20'd1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cap_a   = 1'b0;
        cap_b   = 1'b0;
        cap_op  = 1'b0;
        cap_res = 1'b0;
        unique case (state_q)
            S_A: begin
                if (press) begin
                    cap_a   = 1'b1;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (press) begin
                    cap_b   = 1'b1;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (press) begin
                    cap_op  = 1'b1;
                    state_d = S_EXEC;
                end
            end
            // A press landing here is simply ignored rather than remembered.
            S_EXEC: begin
                cap_res = 1'b1;
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (press) begin
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            op_reg  <= '0;
            res_reg <= '0;
            n_reg   <= 1'b0;
            z_reg   <= 1'b0;
            p_reg   <= 1'b0;
            ledr    <= '0;
        end else begin
            if (cap_a)  a_reg  <= {6'b0, sw};
            if (cap_b)  b_reg  <= {6'b0, sw};
            if (cap_op) op_reg <= {2'b00, sw[1:0]};
            if (cap_res) begin
                res_reg <= alu.alu_result;
                n_reg   <= alu.alu_n;
                z_reg   <= alu.alu_z;
                p_reg   <= alu.alu_p;
            end
            unique case (state_q)
                S_A, S_B, S_OP: ledr <= {state_q[1:0], sw[7:0]};
                S_SHOW:         ledr <= {n_reg, z_reg, p_reg, res_reg[6:0]};
                default:        ledr <= ledr;
            endcase
        end
    end

    // Upper result bits are kept for completeness but never reach the LEDs.
    logic unused_res;
    assign unused_res = ^res_reg[15:7];

    assign alu.alu_a  = a_reg;
    assign alu.alu_b  = b_reg;
    assign alu.alu_op = op_reg;
    assign state      = state_q;

endmodule

// File: doc/fpga_step_loader.md
FPGA_STEP_LOADER -- requirements
Module: fpga_step_loader

Interface
REQ-001 Parameter DB_CYCLES, default 250000, is the debounce window in clk cycles (5 ms at 50 MHz), legal range 2..2^20-1.
REQ-002 clk  input  1  the only clock; all logic is on its rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 sw  input  10  board switches; operand and opcode source.
REQ-005 key_step  input  1  raw pushbutton, active-low, asynchronous and bouncy.
REQ-006 alu_a, alu_b  output  16  operands to the external ALU.
REQ-007 alu_op  output  4  opcode to the ALU: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
REQ-008 alu_result  input  16  combinational result from the ALU.
REQ-009 alu_n, alu_z, alu_p  input  1 each  ALU sign flags.
REQ-010 ledr  output  10  board LEDs, registered.
REQ-011 state  output  3  current FSM state, for debug.

Function
REQ-012 key_step SHALL pass through a 2-flop synchronizer with reset value 1.
REQ-013 Debouncer: a counter SHALL increment while the synchronized level differs from the debounced level, and SHALL clear to 0 when they are equal.
REQ-014 When the counter equals DB_CYCLES-1 and the levels still differ, the debounced level SHALL take the synchronized value and the counter SHALL clear.
REQ-015 A single-cycle registered press pulse SHALL assert on the same edge that the debounced level goes 1->0; a release (0->1) SHALL NOT produce a pulse.
REQ-016 Latency: if key_step is held low from edge 0 (the first edge that samples it low), the FSM SHALL act on the press at edge DB_CYCLES+2.
REQ-017 States and encodings: S_A=000, S_B=001, S_OP=010, S_EXEC=011, S_SHOW=100.
REQ-018 S_A + press: a_reg <= {6'b0, sw}, then go to S_B.
REQ-019 S_B + press: b_reg <= {6'b0, sw}, then go to S_OP.
REQ-020 S_OP + press: op_reg <= {2'b00, sw[1:0]}, then go to S_EXEC.
REQ-021 S_EXEC SHALL last exactly one cycle: res_reg <= alu_result, {n,z,p}_reg <= {alu_n, alu_z, alu_p}, then go to S_SHOW unconditionally.
REQ-022 A press pulse arriving in S_EXEC SHALL be dropped; it SHALL NOT be queued.
REQ-023 S_SHOW + press: go to S_A; a_reg, b_reg, op_reg, res_reg and the flags SHALL be retained until they are overwritten.
REQ-024 Without a press pulse, every state except S_EXEC SHALL hold.
REQ-025 alu_a = a_reg, alu_b = b_reg and alu_op = op_reg SHALL be driven continuously.
REQ-026 Operand width: 10-bit zero-extended, so the SUB result wraps modulo 2^16 (e.g. 3-5 = 16'hFFFE).
REQ-027 ledr in S_A/S_B/S_OP SHALL be {state[1:0], sw[7:0]}, registered with one-cycle latency from sw.
REQ-028 ledr in S_EXEC SHALL hold its previous value.
REQ-029 ledr in S_SHOW SHALL be {n_reg, z_reg, p_reg, res_reg[6:0]}.
REQ-030 The flags SHALL be used exactly as returned by the ALU; this block SHALL NOT recompute them.

Reset
REQ-031 With rst_n low at an edge: state=S_A; a_reg=b_reg=res_reg=0; op_reg=0000; flag regs=0; ledr=0; synchronizer flops=1; debounced level=1; counter=0; press pulse=0.
REQ-032 Reset mid-operation (any state, including S_EXEC) SHALL abandon the sequence without capturing; reset SHALL dominate a coincident press.
REQ-033 If key_step is held low through reset release, one press SHALL be generated DB_CYCLES+2 edges after release.
REQ-034 The block SHALL NOT depend on ALU outputs during reset.

Verification (DB_CYCLES=4)
REQ-035 Reset, then key_step held high for 20 cycles -> state=000, alu_a=alu_b=0, ledr={00, sw[7:0]} one edge after reset release.
REQ-036 Presses with sw=10'd3, 10'd5, 10'b01 (SUB), with a model ALU -> state reaches 100; ledr=10'b1_0_0_1111110 (N=1, result[6:0]=7'h7E for 16'hFFFE).
REQ-037 key_step bounces low for 3 cycles, high for 1, repeated 5 times, then released -> no press, state unchanged.
REQ-038 Single clean press held for 10 cycles -> press pulse high for exactly one cycle at edge 5, state advances once, release causes no advance.
REQ-039 ADD with A=10'd0, B=10'd0 -> in S_SHOW, ledr=10'b0_1_0_0000000 (Z=1).
REQ-040 rst_n pulsed low while in S_OP -> state=000 and operand regs=0 on the next edge; a subsequent full sequence completes normally.
